// File: rtl/control_block.sv
// Test sequencer: issues write/read address transactions in fixed, running or
// pseudo-random address order and reports a pass/fail result at test end.
module control_block #(
  parameter int          ADDR_W   = 31,
  parameter logic [31:0] RND_SEED = 32'hFFFF_FFFF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_test_i,
  input  logic [1:0]        test_mode_i,
  input  logic [1:0]        addr_mode_i,
  input  logic [31:0]       trans_count_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0] addr_step_i,
  input  logic              trans_ready_i,
  input  logic              trans_busy_i,
  input  logic              cmp_error_i,
  output logic              trans_valid_o,
  output logic [ADDR_W-1:0] trans_addr_o,
  output logic              trans_type_o,
  output logic              test_finished_o,
  output logic              test_result_o,
  output logic [31:0]       addr_done_cnt_o
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_WR,
    ISSUE_RD,
    WAIT_DONE,
    FINISH
  } state_t;

  state_t              state;
  logic                wac_q;
  logic                run_q;
  logic                rnd_q;
  logic [31:0]         count_q;
  logic [ADDR_W-1:0]   step_q;
  logic [31:0]         lfsr;
  logic                err_q;

  logic                xfer;
  logic                addr_complete;
  logic                last_addr;
  logic [31:0]         cnt_inc;
  logic [31:0]         lfsr_adv;
  logic [ADDR_W-1:0]   next_addr;

  // Fibonacci LFSR, taps 32,22,2,1 (bits 31,21,1,0), shifting toward the MSB.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  // In write-and-check mode an address is only complete once its read-back is issued.
  always_comb begin
    xfer          = trans_valid_o && trans_ready_i;
    addr_complete = xfer && (!wac_q || (state == ISSUE_RD));
    cnt_inc       = addr_done_cnt_o + 32'd1;
    last_addr     = (cnt_inc == count_q);
    lfsr_adv      = lfsr_next(lfsr);
    next_addr     = trans_addr_o;
    if (rnd_q)
      next_addr = lfsr_adv[ADDR_W-1:0];
    else if (run_q)
      next_addr = trans_addr_o + step_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state           <= IDLE;
      wac_q           <= 1'b0;
      run_q           <= 1'b0;
      rnd_q           <= 1'b0;
      count_q         <= '0;
      step_q          <= '0;
      lfsr            <= RND_SEED;
      err_q           <= 1'b0;
      trans_valid_o   <= 1'b0;
      trans_addr_o    <= '0;
      trans_type_o    <= 1'b0;
      test_finished_o <= 1'b0;
      test_result_o   <= 1'b0;
      addr_done_cnt_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_test_i) begin
            wac_q           <= (test_mode_i == 2'd2);
            run_q           <= (addr_mode_i == 2'd1);
            rnd_q           <= (addr_mode_i == 2'd2);
            count_q         <= trans_count_i;
            step_q          <= addr_step_i;
            lfsr            <= RND_SEED;
            trans_addr_o    <= (addr_mode_i == 2'd2) ? RND_SEED[ADDR_W-1:0] : base_addr_i;
            addr_done_cnt_o <= '0;
            err_q           <= 1'b0;
            test_result_o   <= 1'b0;
            if (trans_count_i == 32'd0) begin
              state <= WAIT_DONE;
            end else if (test_mode_i == 2'd1 || test_mode_i == 2'd2) begin
              state         <= ISSUE_WR;
              trans_valid_o <= 1'b1;
              trans_type_o  <= 1'b0;
            end else begin
              state         <= ISSUE_RD;
              trans_valid_o <= 1'b1;
              trans_type_o  <= 1'b1;
            end
          end
        end

        ISSUE_WR, ISSUE_RD: begin
          if (addr_complete) begin
            addr_done_cnt_o <= cnt_inc;
            trans_addr_o    <= next_addr;
            if (rnd_q)
              lfsr <= lfsr_adv;
          end
          // An error abort still lets a same-cycle transfer be counted above.
          if (cmp_error_i) begin
            err_q         <= 1'b1;
            state         <= WAIT_DONE;
            trans_valid_o <= 1'b0;
          end else if (addr_complete && last_addr) begin
            state         <= WAIT_DONE;
            trans_valid_o <= 1'b0;
          end else if (addr_complete && wac_q) begin
            state        <= ISSUE_WR;
            trans_type_o <= 1'b0;
          end else if (xfer && wac_q) begin
            state        <= ISSUE_RD;
            trans_type_o <= 1'b1;
          end
        end

        WAIT_DONE: begin
          if (cmp_error_i)
            err_q <= 1'b1;
          if (!trans_busy_i) begin
            state           <= FINISH;
            test_finished_o <= 1'b1;
            test_result_o   <= err_q | cmp_error_i;
          end
        end

        FINISH: begin
          test_finished_o <= 1'b0;
          state           <= IDLE;
        end

        default: begin
          state           <= IDLE;
          trans_valid_o   <= 1'b0;
          test_finished_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
